// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control front-end.
// The state encoding is shared so the counter chain and any status logic agree on it.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level counter and a one-cycle
// press pulse on each debounced 1->0 transition of an active-low button.
module btn_debounce #(
  parameter int DB_CNT = 250000
) (
  input  logic clk,
  input  logic nclr,
  input  logic nbtn,
  output logic press
);

  localparam int             CW       = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: every register here uses <= so all flops sample pre-edge values;
  // a blocking '=' would let sync2 see this cycle's sync1 and collapse the synchronizer.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= nbtn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Disagreement has lasted DB_CNT cycles: accept the new level.
        cnt   <= '0;
        level <= sync2;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: debounced start/stop and clear buttons, the
// IDLE/RUN/PAUSE state machine, the 1/100 s tick prescaler and the counter clear.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DIV    = 500000,
  parameter int DB_CNT = 250000
) (
  input  logic clk,
  input  logic nclr,
  input  logic nbtn_ss,
  input  logic nbtn_rst,
  output logic tick,
  output logic cnt_nclr,
  output logic running
);

  localparam int            PW       = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          ss_press;
  logic          rst_press;

  btn_debounce #(.DB_CNT(DB_CNT)) u_ss_db (
    .clk   (clk),
    .nclr  (nclr),
    .nbtn  (nbtn_ss),
    .press (ss_press)
  );

  btn_debounce #(.DB_CNT(DB_CNT)) u_rst_db (
    .clk   (clk),
    .nclr  (nclr),
    .nbtn  (nbtn_rst),
    .press (rst_press)
  );

  assign tick = (state == ST_RUN) && (prescaler == PRE_LAST);

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      state     <= ST_IDLE;
      prescaler <= '0;
      cnt_nclr  <= 1'b0;
      running   <= 1'b0;
    end else begin
      cnt_nclr <= 1'b1;
      if (state == ST_RUN) begin
        prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
      end
      // Start/stop always takes priority over clear when both arrive together.
      case (state)
        ST_IDLE: begin
          if (ss_press) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (ss_press) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (ss_press) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else if (rst_press) begin
            state     <= ST_IDLE;
            prescaler <= '0;
            cnt_nclr  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (DIV=4, DB_CNT=3): directed scenarios plus random button
// activity, compared every cycle against a button-history / elapsed-run-time model.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;
  localparam int DB  = 3;

  logic clk      = 1'b0;
  logic nclr     = 1'b1;
  logic nbtn_ss  = 1'b1;
  logic nbtn_rst = 1'b1;
  logic tick;
  logic cnt_nclr;
  logic running;

  int errors = 0;
  int checks = 0;

  stopwatch_ctrl #(.DIV(DIV), .DB_CNT(DB)) dut (
    .clk      (clk),
    .nclr     (nclr),
    .nbtn_ss  (nbtn_ss),
    .nbtn_rst (nbtn_rst),
    .tick     (tick),
    .cnt_nclr (cnt_nclr),
    .running  (running)
  );

  always #5 clk = ~clk;

  // Model: raw button history per edge, debounced levels, pending press events,
  // and the number of completed RUN cycles since the last clear.
  logic [7:0] h_ss, h_rst;
  bit   lvl_ss, lvl_rst, pr_ss, pr_rst;
  bit   m_run, m_pause, m_clr;
  int   m_elapsed;

  // Observation tallies (what the DUT did), compared against spec values by the tests.
  int    cyc = 0;
  int    mm;
  string mm_first;
  int    n_tick, n_run, n_clr, rise_cyc, gap;
  bit    obs_run;

  function automatic bit settles(input logic [7:0] h, input bit lvl);
    // The synchronized level lags the raw button by two edges.
    for (int j = 2; j < DB + 2; j++) if (h[j] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    h_ss = 8'hFF; h_rst = 8'hFF;
    lvl_ss = 1'b1; lvl_rst = 1'b1; pr_ss = 1'b0; pr_rst = 1'b0;
    m_run = 1'b0; m_pause = 1'b0; m_clr = 1'b0; m_elapsed = 0;
    obs_run = 1'b0;
  endtask

  task automatic step();
    bit         was_run;
    logic [2:0] want;
    @(posedge clk);
    cyc++;
    if (nclr) begin
      was_run = m_run;
      m_clr   = 1'b0;
      if (pr_ss) begin
        m_run   = !was_run;
        m_pause = was_run;
      end else if (pr_rst && m_pause) begin
        m_pause   = 1'b0;
        m_clr     = 1'b1;
        m_elapsed = 0;
      end
      if (was_run) m_elapsed++;
      h_ss  = {h_ss[6:0], nbtn_ss};
      h_rst = {h_rst[6:0], nbtn_rst};
      pr_ss  = 1'b0;
      pr_rst = 1'b0;
      if (settles(h_ss, lvl_ss)) begin
        lvl_ss = !lvl_ss;
        pr_ss  = !lvl_ss;
      end
      if (settles(h_rst, lvl_rst)) begin
        lvl_rst = !lvl_rst;
        pr_rst  = !lvl_rst;
      end
    end
    #1;
    want = {m_run && ((m_elapsed + 1) % DIV == 0), m_run, nclr ? !m_clr : 1'b0};
    if ({tick, running, cnt_nclr} !== want) begin
      if (mm == 0)
        mm_first = $sformatf("cycle %0d got tick/run/nclr=%b want %b", cyc, {tick, running, cnt_nclr}, want);
      mm++;
    end
    if (nclr) begin
      if (running && !obs_run) begin
        rise_cyc = cyc;
        gap      = -1;
      end
      if (tick && gap < 0) gap = cyc - rise_cyc;
      obs_run = running;
      if (tick)      n_tick++;
      if (running)   n_run++;
      if (!cnt_nclr) n_clr++;
    end
  endtask

  task automatic tap(input bit ss, input bit rst, input int lo, input int hi);
    nbtn_ss  = !ss;
    nbtn_rst = !rst;
    repeat (lo) step();
    nbtn_ss  = 1'b1;
    nbtn_rst = 1'b1;
    repeat (hi) step();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    nclr = 1'b0; nbtn_ss = 1'b1; nbtn_rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nclr = 1'b1;
  endtask

  task automatic test_reset();
    #2 nclr = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({tick, running, cnt_nclr} !== 3'b000) begin
      errors++; $display("FAIL reset_async: got tick/run/nclr=%b want 000", {tick, running, cnt_nclr});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    nclr = 1'b1;
    #1;
    checks++;
    if (cnt_nclr !== 1'b0) begin
      errors++; $display("FAIL reset_hold_clr: cnt_nclr=%b want 0 before first edge", cnt_nclr);
    end
    mm = 0; n_clr = 0; n_tick = 0; n_run = 0;
    step();
    checks++;
    if (cnt_nclr !== 1'b1) begin
      errors++; $display("FAIL reset_first_edge: cnt_nclr=%b want 1", cnt_nclr);
    end
    repeat (49) step();
    checks++;
    if (n_clr != 0 || n_tick != 0 || n_run != 0) begin
      errors++; $display("FAIL reset_idle: clr=%0d tick=%0d run=%0d cycles, want 0 0 0", n_clr, n_tick, n_run);
    end
    checks++;
    if (mm != 0) begin
      errors++; $display("FAIL reset_model: %0d cycles off, first %s", mm, mm_first);
    end
  endtask

  task automatic test_press_run();
    int start;
    mm = 0; n_tick = 0; n_run = 0; rise_cyc = -100; gap = -1;
    start = cyc;
    nbtn_ss = 1'b0;
    repeat (20) step();
    nbtn_ss = 1'b1;
    repeat (10) step();
    checks++;
    if (rise_cyc - start != 6) begin
      errors++; $display("FAIL press_latency: running rose after %0d edges, want 6", rise_cyc - start);
    end
    checks++;
    if (gap != DIV - 1) begin
      errors++; $display("FAIL first_tick: tick %0d cycles after run, want %0d", gap, DIV - 1);
    end
    checks++;
    if (n_tick != 6) begin
      errors++; $display("FAIL tick_period: %0d ticks in 30 cycles, want 6", n_tick);
    end
    checks++;
    if (n_run != 25) begin
      errors++; $display("FAIL held_button: running high %0d cycles, want 25", n_run);
    end
    checks++;
    if (mm != 0) begin
      errors++; $display("FAIL press_run_model: %0d cycles off, first %s", mm, mm_first);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    mm = 0; n_tick = 0; n_run = 0;
    tap(1'b1, 1'b0, 2, 20);
    checks++;
    if (n_tick != 0 || n_run != 0) begin
      errors++; $display("FAIL glitch: tick=%0d run=%0d cycles, want 0 0", n_tick, n_run);
    end
    checks++;
    if (mm != 0) begin
      errors++; $display("FAIL glitch_model: %0d cycles off, first %s", mm, mm_first);
    end
  endtask

  task automatic test_pause_resume();
    apply_reset();
    mm = 0;
    tap(1'b1, 1'b0, 5, 5);
    nbtn_ss = 1'b0;
    repeat (5) step();
    nbtn_ss = 1'b1;
    step();
    n_tick = 0; n_run = 0;
    repeat (30) step();
    checks++;
    if (n_tick != 0 || n_run != 0) begin
      errors++; $display("FAIL pause_hold: tick=%0d run=%0d cycles, want 0 0", n_tick, n_run);
    end
    tap(1'b1, 1'b0, 5, 6);
    checks++;
    if (gap != 1) begin
      errors++; $display("FAIL resume_tick: tick %0d cycles after resume, want 1", gap);
    end
    checks++;
    if (mm != 0) begin
      errors++; $display("FAIL pause_model: %0d cycles off, first %s", mm, mm_first);
    end
  endtask

  task automatic test_clear();
    mm = 0; n_clr = 0;
    tap(1'b0, 1'b1, 5, 6);
    checks++;
    if (n_clr != 0 || running !== 1'b1) begin
      errors++; $display("FAIL rst_in_run: clr=%0d running=%b, want 0 1", n_clr, running);
    end
    tap(1'b1, 1'b0, 5, 6);
    tap(1'b0, 1'b1, 5, 6);
    checks++;
    if (n_clr != 1) begin
      errors++; $display("FAIL clear_pulse: cnt_nclr low %0d cycles, want 1", n_clr);
    end
    tap(1'b0, 1'b1, 5, 6);
    checks++;
    if (n_clr != 1 || running !== 1'b0) begin
      errors++; $display("FAIL rst_in_idle: clr=%0d running=%b, want 1 0", n_clr, running);
    end
    tap(1'b1, 1'b0, 5, 6);
    checks++;
    if (gap != DIV - 1) begin
      errors++; $display("FAIL tick_after_clear: tick %0d cycles after run, want %0d", gap, DIV - 1);
    end
    checks++;
    if (mm != 0) begin
      errors++; $display("FAIL clear_model: %0d cycles off, first %s", mm, mm_first);
    end
  endtask

  task automatic test_simultaneous();
    mm = 0;
    tap(1'b1, 1'b0, 5, 6);
    n_clr = 0;
    tap(1'b1, 1'b1, 5, 6);
    checks++;
    if (running !== 1'b1 || n_clr != 0) begin
      errors++; $display("FAIL simultaneous: running=%b clr=%0d, want 1 0", running, n_clr);
    end
    checks++;
    if (mm != 0) begin
      errors++; $display("FAIL simultaneous_model: %0d cycles off, first %s", mm, mm_first);
    end
  endtask

  task automatic test_reset_mid_run();
    int rel;
    mm = 0;
    nbtn_ss = 1'b0;
    repeat (2) step();
    @(negedge clk);
    nclr = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({tick, running, cnt_nclr} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_run: got tick/run/nclr=%b want 000", {tick, running, cnt_nclr});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    nclr = 1'b1;
    rel = cyc;
    rise_cyc = -100;
    repeat (8) step();
    nbtn_ss = 1'b1;
    repeat (6) step();
    checks++;
    if (rise_cyc - rel != 6) begin
      errors++; $display("FAIL reset_discards_count: running rose after %0d edges, want 6", rise_cyc - rel);
    end
    checks++;
    if (mm != 0) begin
      errors++; $display("FAIL reset_mid_model: %0d cycles off, first %s", mm, mm_first);
    end
  endtask

  task automatic test_random();
    apply_reset();
    mm = 0;
    for (int s = 0; s < 150; s++) begin
      nbtn_ss  = 1'($urandom_range(0, 1));
      nbtn_rst = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) step();
    end
    nbtn_ss  = 1'b1;
    nbtn_rst = 1'b1;
    repeat (10) step();
    checks++;
    if (mm != 0) begin
      errors++; $display("FAIL random_model: %0d cycles off, first %s", mm, mm_first);
    end
  endtask

  initial begin
    test_reset();
    test_press_run();
    test_glitch();
    test_pause_resume();
    test_clear();
    test_simultaneous();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control front-end for the stopwatch counter chain. It debounces the two push buttons, runs the start/stop/clear state machine, and drives the counters' inputs.
- Produces the 1/100 s count-enable pulse that feeds the carry-in of the least-significant digit counter.
- Produces the active-low clear for the whole counter chain.
- Sits directly upstream of the cascaded BCD digit counters.

Parameters:
DIV, 500000, clock cycles per count tick (50 MHz / 100 Hz); legal range DIV >= 2
DB_CNT, 250000, consecutive stable cycles required before a debounced button level changes (5 ms); legal range DB_CNT >= 1

Ports:
clk  input  1  system clock, rising edge
nclr  input  1  asynchronous active-low reset of this block
nbtn_ss  input  1  start/stop push button, active-low, asynchronous to clk
nbtn_rst  input  1  clear push button, active-low, asynchronous to clk
tick  output  1  one-cycle count enable to the first digit counter's carry-in
cnt_nclr  output  1  active-low clear to all digit counters
running  output  1  high while in RUN state

Behaviour:
- Clocking and reset: one clock, clk. Reset nclr is asynchronous and active-low.
- State during reset: IDLE, prescaler = 0, synchronizers = 1, debounced levels = 1.
- Outputs during reset: tick = 0, cnt_nclr = 0, running = 0.
- Input synchronization: each button passes through a 2-FF synchronizer.
- Debounce: the debounced level copies the synchronized level only after the two have differed for DB_CNT consecutive cycles. Any agreement in between restarts the count.
- Press event: a one-cycle pulse on a 1->0 transition of the debounced level. Release generates no event.
- Press latency: a clean button edge produces its press pulse 2 + DB_CNT cycles after the edge (±1 cycle for asynchronous sampling).
- FSM states: IDLE (stopped, counters zero), RUN, PAUSE (stopped, counters hold).
  - IDLE: ss press -> RUN. rst press is ignored.
  - RUN: ss press -> PAUSE. rst press is ignored.
  - PAUSE: ss press -> RUN. rst press -> IDLE.
  - Simultaneous ss and rst press in the same cycle: ss wins and rst is discarded.
- Prescaler:
  - Width is ceil(log2(DIV)).
  - Increments only in RUN. Wraps from DIV-1 to 0.
  - Holds its value in PAUSE, so resume continues the partial interval.
  - Forced to 0 on the PAUSE->IDLE transition.
- tick: combinational, = (state==RUN) && (prescaler==DIV-1). From IDLE, the first tick occurs in the DIV-th cycle spent in RUN, then every DIV cycles. tick is never high outside RUN.
- cnt_nclr: registered. Low for exactly one clk cycle, the cycle after the PAUSE->IDLE transition edge. Otherwise high, except during nclr reset when it is 0. It goes 1 on the first clk edge after reset release.
- running: registered copy of (state==RUN).
- Reset mid-operation: nclr asserted in any state immediately forces the reset values. Any pending debounce count is discarded.
- Held button: a held button produces exactly one press event. Bounce shorter than DB_CNT cycles produces none.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2.
- Unused encoding 2'd3 recovers to IDLE on the next edge.
- One sub-module, btn_debounce (synchronizer + stable counter + press pulse), parameterized by DB_CNT and instantiated twice.
- FSM and prescaler stay in stopwatch_ctrl.

Test Plan:
(DIV=4, DB_CNT=3 for all scenarios)
- Reset release, no buttons -> tick=0, running=0; cnt_nclr goes 0->1 on the first edge after release and stays 1 for 50 cycles.
- ss low held 20 cycles from IDLE -> single press pulse ~5 cycles after the edge; running=1 next cycle; tick high in RUN cycles 4, 8, 12 (period 4, width 1); held button produces no further transitions.
- ss glitch low for 2 cycles, then high -> no press event; state stays IDLE; tick stays 0.
- RUN for 6 cycles (prescaler=2), ss press -> PAUSE, tick stays 0 for 30 cycles; ss press -> RUN, first tick 2 cycles after re-entry.
- In PAUSE, rst press -> IDLE; cnt_nclr low exactly 1 cycle; prescaler 0; next ss press gives first tick after 4 RUN cycles. rst press in RUN or IDLE -> no cnt_nclr pulse, no state change.
- ss and rst pressed in the same cycle in PAUSE -> RUN, no cnt_nclr pulse. Separately, nclr asserted mid-RUN -> tick=0, running=0, cnt_nclr=0 asynchronously, state IDLE after release.
